// File: rtl/vga_pkg.sv
// Shared VGA timing constants (800x600@72 Hz defaults) and a small decode helper.
package vga_pkg;

    localparam int COORD_W = 11;

    localparam int H_VISIBLE_DEF = 800;
    localparam int H_FRONT_DEF   = 56;
    localparam int H_SYNC_DEF    = 120;
    localparam int H_BACK_DEF    = 64;
    localparam int H_TOTAL_DEF   = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;

    localparam int V_VISIBLE_DEF = 600;
    localparam int V_FRONT_DEF   = 37;
    localparam int V_SYNC_DEF    = 6;
    localparam int V_BACK_DEF    = 23;
    localparam int V_TOTAL_DEF   = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

    // Half-open interval test [lo, hi) on a coordinate.
    function automatic logic inRange(input logic [COORD_W-1:0] v, input int lo, input int hi);
        return (int'(v) >= lo) && (int'(v) < hi);
    endfunction

endpackage

// File: rtl/wrap_counter.sv
// Modulo counter with enable; exposes its next value so callers can register decodes in step.
module wrap_counter
    import vga_pkg::*;
#(
    parameter int MODULUS = 2,
    parameter int WIDTH   = COORD_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_count,
    output logic [WIDTH-1:0] o_next,
    output logic             o_wrap
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] r_count;

    always_comb begin
        o_wrap = i_en && (r_count == LAST);
        o_next = r_count;
        if (i_en) begin
            o_next = o_wrap ? '0 : r_count + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else begin
            r_count <= o_next;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator with a vblank-aligned game-step strobe.
// Every output is registered from next-state counter values so it lines up with CurrentX/CurrentY.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int   H_VISIBLE   = H_VISIBLE_DEF,
    parameter int   H_FRONT     = H_FRONT_DEF,
    parameter int   H_SYNC      = H_SYNC_DEF,
    parameter int   H_BACK      = H_BACK_DEF,
    parameter int   V_VISIBLE   = V_VISIBLE_DEF,
    parameter int   V_FRONT     = V_FRONT_DEF,
    parameter int   V_SYNC      = V_SYNC_DEF,
    parameter int   V_BACK      = V_BACK_DEF,
    parameter logic SYNC_POL    = 1'b1,
    parameter int   TICK_FRAMES = 9
) (
    input  logic               CLK_100MHz,
    input  logic               Reset,
    output logic [COORD_W-1:0] CurrentX,
    output logic [COORD_W-1:0] CurrentY,
    output logic               HBlank,
    output logic               VBlank,
    output logic               HSync,
    output logic               VSync,
    output logic               PixelEn,
    output logic               FrameStart,
    output logic               CLK_update
);

    localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_START = H_VISIBLE + H_FRONT;
    localparam int VS_START = V_VISIBLE + V_FRONT;

    logic               r_pixelEn;
    logic               r_hBlank;
    logic               r_vBlank;
    logic               r_hSync;
    logic               r_vSync;
    logic               r_frameStart;
    logic               r_clkUpdate;

    logic [COORD_W-1:0] w_hCount;
    logic [COORD_W-1:0] w_hNext;
    logic               w_hWrap;
    logic [COORD_W-1:0] w_vCount;
    logic [COORD_W-1:0] w_vNext;
    logic               w_vWrap;
    logic [COORD_W-1:0] w_tickCount;
    logic [COORD_W-1:0] w_tickNext;
    logic               w_tickWrap;
    logic               w_enterVbl;
    logic               w_leaveVbl;
    logic               w_unusedTick;

    wrap_counter #(.MODULUS(H_TOTAL), .WIDTH(COORD_W)) u_hCounter (
        .clk     (CLK_100MHz),
        .rst     (Reset),
        .i_en    (r_pixelEn),
        .o_count (w_hCount),
        .o_next  (w_hNext),
        .o_wrap  (w_hWrap)
    );

    wrap_counter #(.MODULUS(V_TOTAL), .WIDTH(COORD_W)) u_vCounter (
        .clk     (CLK_100MHz),
        .rst     (Reset),
        .i_en    (w_hWrap),
        .o_count (w_vCount),
        .o_next  (w_vNext),
        .o_wrap  (w_vWrap)
    );

    // Frames are counted at vblank entry so the strobe always lands in blanking.
    assign w_enterVbl = w_hWrap && (int'(w_vNext) == V_VISIBLE);
    assign w_leaveVbl = w_hWrap && (int'(w_vNext) == V_VISIBLE + 1);

    wrap_counter #(.MODULUS(TICK_FRAMES), .WIDTH(COORD_W)) u_tickCounter (
        .clk     (CLK_100MHz),
        .rst     (Reset),
        .i_en    (w_enterVbl),
        .o_count (w_tickCount),
        .o_next  (w_tickNext),
        .o_wrap  (w_tickWrap)
    );

    assign w_unusedTick = ^{w_tickCount, w_tickNext};

    always_ff @(posedge CLK_100MHz or posedge Reset) begin
        if (Reset) begin
            r_pixelEn    <= 1'b0;
            r_hBlank     <= 1'b0;
            r_vBlank     <= 1'b0;
            r_hSync      <= ~SYNC_POL;
            r_vSync      <= ~SYNC_POL;
            r_frameStart <= 1'b0;
            r_clkUpdate  <= 1'b0;
        end else begin
            r_pixelEn    <= ~r_pixelEn;
            r_hBlank     <= inRange(w_hNext, H_VISIBLE, H_TOTAL);
            r_vBlank     <= inRange(w_vNext, V_VISIBLE, V_TOTAL);
            r_hSync      <= inRange(w_hNext, HS_START, HS_START + H_SYNC) ? SYNC_POL : ~SYNC_POL;
            r_vSync      <= inRange(w_vNext, VS_START, VS_START + V_SYNC) ? SYNC_POL : ~SYNC_POL;
            r_frameStart <= w_vWrap;
            if (w_enterVbl && w_tickWrap) begin
                r_clkUpdate <= 1'b1;
            end else if (w_leaveVbl) begin
                r_clkUpdate <= 1'b0;
            end
        end
    end

    assign CurrentX   = w_hCount;
    assign CurrentY   = w_vCount;
    assign HBlank     = r_hBlank;
    assign VBlank     = r_vBlank;
    assign HSync      = r_hSync;
    assign VSync      = r_vSync;
    assign PixelEn    = r_pixelEn;
    assign FrameStart = r_frameStart;
    assign CLK_update = r_clkUpdate;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: a default 800x600 instance for line timing, two shrunken instances for frame/strobe timing.
module tb_vga_timing_gen;

    // Shrunken raster: 15 pixels x 11 lines, hsync X 10..12, vsync Y 8..9, vblank from Y=6
    localparam int SH = 15;
    localparam int SV = 11;
    localparam int SVV = 6;

    logic clk = 1'b0;
    logic rst;
    int   cyc;
    int   testsRun;
    int   testsFailed;

    logic [10:0] xA, yA, xB, yB, xC, yC;
    logic hbA, vbA, hsA, vsA, peA, fsA, upA;
    logic hbB, vbB, hsB, vsB, peB, fsB, upB;
    logic hbC, vbC, hsC, vsC, peC, fsC, upC;

    always #5 clk = ~clk;

    // Clock edges since reset release; the reference model is a closed form of this count
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    vga_timing_gen #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(1),
        .SYNC_POL(1'b1), .TICK_FRAMES(3)
    ) dutA (
        .CLK_100MHz(clk), .Reset(rst), .CurrentX(xA), .CurrentY(yA), .HBlank(hbA), .VBlank(vbA),
        .HSync(hsA), .VSync(vsA), .PixelEn(peA), .FrameStart(fsA), .CLK_update(upA)
    );

    vga_timing_gen #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(1),
        .SYNC_POL(1'b0), .TICK_FRAMES(1)
    ) dutB (
        .CLK_100MHz(clk), .Reset(rst), .CurrentX(xB), .CurrentY(yB), .HBlank(hbB), .VBlank(vbB),
        .HSync(hsB), .VSync(vsB), .PixelEn(peB), .FrameStart(fsB), .CLK_update(upB)
    );

    vga_timing_gen dutC (
        .CLK_100MHz(clk), .Reset(rst), .CurrentX(xC), .CurrentY(yC), .HBlank(hbC), .VBlank(vbC),
        .HSync(hsC), .VSync(vsC), .PixelEn(peC), .FrameStart(fsC), .CLK_update(upC)
    );

    function automatic int mX(input int c, input int ht);
        return (c / 2) % ht;
    endfunction

    function automatic int mY(input int c, input int ht, input int vt);
        return ((c / 2) / ht) % vt;
    endfunction

    function automatic int mF(input int c, input int ht, input int vt);
        return (c / 2) / (ht * vt);
    endfunction

    function automatic logic mFs(input int c, input int ht, input int vt);
        return (c > 0) && (c % 2 == 0) && ((c / 2) % (ht * vt) == 0);
    endfunction

    function automatic logic mUp(input int c, input int ht, input int vt, input int vv, input int t);
        return (mY(c, ht, vt) == vv) && (mF(c, ht, vt) % t == t - 1);
    endfunction

    task automatic applyReset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        testsRun++; if (xA !== 11'd0) begin testsFailed++; $display("[TB] FAIL rstXA got %0d want 0", xA); end
        testsRun++; if (yA !== 11'd0) begin testsFailed++; $display("[TB] FAIL rstYA got %0d want 0", yA); end
        testsRun++; if (peA !== 1'b0) begin testsFailed++; $display("[TB] FAIL rstPeA got %b want 0", peA); end
        testsRun++; if (hbA !== 1'b0) begin testsFailed++; $display("[TB] FAIL rstHbA got %b want 0", hbA); end
        testsRun++; if (vbA !== 1'b0) begin testsFailed++; $display("[TB] FAIL rstVbA got %b want 0", vbA); end
        testsRun++; if (hsA !== 1'b0) begin testsFailed++; $display("[TB] FAIL rstHsA got %b want 0", hsA); end
        testsRun++; if (vsA !== 1'b0) begin testsFailed++; $display("[TB] FAIL rstVsA got %b want 0", vsA); end
        testsRun++; if (fsA !== 1'b0) begin testsFailed++; $display("[TB] FAIL rstFsA got %b want 0", fsA); end
        testsRun++; if (upA !== 1'b0) begin testsFailed++; $display("[TB] FAIL rstUpA got %b want 0", upA); end
        testsRun++; if (hsB !== 1'b1) begin testsFailed++; $display("[TB] FAIL rstHsB got %b want 1", hsB); end
        testsRun++; if (vsB !== 1'b1) begin testsFailed++; $display("[TB] FAIL rstVsB got %b want 1", vsB); end
        testsRun++; if ({xC, yC} !== 22'd0) begin testsFailed++; $display("[TB] FAIL rstXYC got %0d/%0d want 0/0", xC, yC); end
    endtask

    task automatic test_startup();
        logic [3:0] peTab;
        int xTab [4] = '{0, 1, 1, 2};
        peTab = 4'b0101;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            testsRun++; if (peA !== peTab[i]) begin testsFailed++; $display("[TB] FAIL startPe%0d got %b want %b", i, peA, peTab[i]); end
            testsRun++; if (int'(xA) !== xTab[i]) begin testsFailed++; $display("[TB] FAIL startX%0d got %0d want %0d", i, xA, xTab[i]); end
            testsRun++; if ({hsA, vsA} !== 2'b00) begin testsFailed++; $display("[TB] FAIL startSyncA%0d got %b%b want 00", i, hsA, vsA); end
            testsRun++; if ({hsB, vsB} !== 2'b11) begin testsFailed++; $display("[TB] FAIL startSyncB%0d got %b%b want 11", i, hsB, vsB); end
            testsRun++; if (fsA !== 1'b0) begin testsFailed++; $display("[TB] FAIL startFs%0d got %b want 0", i, fsA); end
        end
    endtask

    task automatic test_default_line();
        int ex, ey, prevX, wrapCyc, hsCount;
        logic eb, es;
        prevX = -1; wrapCyc = -1; hsCount = 0;
        while (cyc < 4170) begin
            @(negedge clk);
            ex = mX(cyc, 1040);
            ey = mY(cyc, 1040, 666);
            eb = (ex >= 800);
            es = (ex >= 856) && (ex < 976);
            if (prevX == 1039 && xC == 11'd0 && wrapCyc < 0) wrapCyc = cyc;
            prevX = int'(xC);
            if (ey == 0 && hsC === 1'b1) hsCount++;
            testsRun++; if (int'(xC) !== ex) begin testsFailed++; $display("[TB] FAIL defX cyc=%0d got %0d want %0d", cyc, xC, ex); end
            testsRun++; if (int'(yC) !== ey) begin testsFailed++; $display("[TB] FAIL defY cyc=%0d got %0d want %0d", cyc, yC, ey); end
            testsRun++; if (hbC !== eb) begin testsFailed++; $display("[TB] FAIL defHBlank cyc=%0d got %b want %b", cyc, hbC, eb); end
            testsRun++; if (hsC !== es) begin testsFailed++; $display("[TB] FAIL defHSync cyc=%0d got %b want %b", cyc, hsC, es); end
            testsRun++; if ({vbC, vsC, fsC, upC} !== 4'b0000) begin testsFailed++; $display("[TB] FAIL defIdle cyc=%0d got %b%b%b%b want 0000", cyc, vbC, vsC, fsC, upC); end
            testsRun++; if (int'(peC) !== cyc % 2) begin testsFailed++; $display("[TB] FAIL defPe cyc=%0d got %b want %0d", cyc, peC, cyc % 2); end
        end
        testsRun++; if (wrapCyc !== 2080) begin testsFailed++; $display("[TB] FAIL defWrapCycle got %0d want 2080", wrapCyc); end
        testsRun++; if (hsCount !== 240) begin testsFailed++; $display("[TB] FAIL defHSyncWidth got %0d want 240", hsCount); end
    endtask

    task automatic test_small_frames();
        int ex, ey, fsCount, upCountA, upCountB, badUp;
        logic eb, ev, ehs, evs, efs, eupA, eupB;
        fsCount = 0; upCountA = 0; upCountB = 0; badUp = 0;
        applyReset();
        repeat (4 * 2 * SH * SV + 20) begin
            @(negedge clk);
            ex   = mX(cyc, SH);
            ey   = mY(cyc, SH, SV);
            eb   = (ex >= 8);
            ev   = (ey >= SVV);
            ehs  = (ex >= 10) && (ex < 13);
            evs  = (ey >= 8) && (ey < 10);
            efs  = mFs(cyc, SH, SV);
            eupA = mUp(cyc, SH, SV, SVV, 3);
            eupB = mUp(cyc, SH, SV, SVV, 1);
            if (fsA === 1'b1) fsCount++;
            if (upA === 1'b1) upCountA++;
            if (upB === 1'b1) upCountB++;
            if ((upA === 1'b1 && vbA === 1'b0) || (upB === 1'b1 && vbB === 1'b0)) badUp++;
            testsRun++; if (int'(xA) !== ex) begin testsFailed++; $display("[TB] FAIL frmX cyc=%0d got %0d want %0d", cyc, xA, ex); end
            testsRun++; if (int'(yA) !== ey) begin testsFailed++; $display("[TB] FAIL frmY cyc=%0d got %0d want %0d", cyc, yA, ey); end
            testsRun++; if ({hbA, vbA} !== {eb, ev}) begin testsFailed++; $display("[TB] FAIL frmBlank cyc=%0d got %b%b want %b%b", cyc, hbA, vbA, eb, ev); end
            testsRun++; if ({hsA, vsA} !== {ehs, evs}) begin testsFailed++; $display("[TB] FAIL frmSyncA cyc=%0d got %b%b want %b%b", cyc, hsA, vsA, ehs, evs); end
            testsRun++; if (fsA !== efs) begin testsFailed++; $display("[TB] FAIL frmStart cyc=%0d got %b want %b", cyc, fsA, efs); end
            testsRun++; if (upA !== eupA) begin testsFailed++; $display("[TB] FAIL frmUpdA cyc=%0d got %b want %b", cyc, upA, eupA); end
            testsRun++; if ({hsB, vsB} !== {~ehs, ~evs}) begin testsFailed++; $display("[TB] FAIL frmSyncB cyc=%0d got %b%b want %b%b", cyc, hsB, vsB, ~ehs, ~evs); end
            testsRun++; if (upB !== eupB) begin testsFailed++; $display("[TB] FAIL frmUpdB cyc=%0d got %b want %b", cyc, upB, eupB); end
            testsRun++;
            if ({xB, yB, peB, hbB, vbB, fsB} !== {11'(ex), 11'(ey), cyc[0], eb, ev, efs}) begin
                testsFailed++;
                $display("[TB] FAIL frmTimingB cyc=%0d got x=%0d y=%0d pe=%b hb=%b vb=%b fs=%b want x=%0d y=%0d", cyc, xB, yB, peB, hbB, vbB, fsB, ex, ey);
            end
        end
        testsRun++; if (fsCount !== 4) begin testsFailed++; $display("[TB] FAIL frmStartCount got %0d want 4", fsCount); end
        testsRun++; if (upCountA !== 2 * SH) begin testsFailed++; $display("[TB] FAIL frmUpdWidthA got %0d want %0d", upCountA, 2 * SH); end
        testsRun++; if (upCountB !== 4 * 2 * SH) begin testsFailed++; $display("[TB] FAIL frmUpdCountB got %0d want %0d", upCountB, 8 * SH); end
        testsRun++; if (badUp !== 0) begin testsFailed++; $display("[TB] FAIL frmUpdOutsideVbl got %0d want 0", badUp); end
    endtask

    task automatic test_reset_midframe();
        int firstRise, upCount, ex, ey;
        logic eup;
        firstRise = -1; upCount = 0;
        applyReset();
        repeat (2 * (2 * SH * SV) + 2 * 3 * SH) @(negedge clk);
        testsRun++; if ({xA, yA} !== {11'd0, 11'd3}) begin testsFailed++; $display("[TB] FAIL midPos got %0d/%0d want 0/3", xA, yA); end
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        testsRun++; if ({xA, yA} !== 22'd0) begin testsFailed++; $display("[TB] FAIL midRstXY got %0d/%0d want 0/0", xA, yA); end
        testsRun++; if ({peA, hbA, vbA, fsA, upA} !== 5'b0) begin testsFailed++; $display("[TB] FAIL midRstFlags got %b%b%b%b%b want 00000", peA, hbA, vbA, fsA, upA); end
        testsRun++; if ({hsA, vsA, hsB, vsB} !== 4'b0011) begin testsFailed++; $display("[TB] FAIL midRstSync got %b%b%b%b want 0011", hsA, vsA, hsB, vsB); end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3 * 2 * SH * SV + 40) begin
            @(negedge clk);
            ex  = mX(cyc, SH);
            ey  = mY(cyc, SH, SV);
            eup = mUp(cyc, SH, SV, SVV, 3);
            if (upA === 1'b1) begin
                upCount++;
                if (firstRise < 0) firstRise = cyc;
            end
            testsRun++; if ({xA, yA} !== {11'(ex), 11'(ey)}) begin testsFailed++; $display("[TB] FAIL midXY cyc=%0d got %0d/%0d want %0d/%0d", cyc, xA, yA, ex, ey); end
            testsRun++; if (upA !== eup) begin testsFailed++; $display("[TB] FAIL midUpd cyc=%0d got %b want %b", cyc, upA, eup); end
        end
        testsRun++; if (firstRise !== 2 * (2 * SH * SV + SVV * SH)) begin testsFailed++; $display("[TB] FAIL midFirstRise got %0d want %0d", firstRise, 2 * (2 * SH * SV + SVV * SH)); end
        testsRun++; if (upCount !== 2 * SH) begin testsFailed++; $display("[TB] FAIL midUpdWidth got %0d want %0d", upCount, 2 * SH); end
    endtask

    initial begin
        rst = 1'b1;
        testsRun = 0;
        testsFailed = 0;
        test_reset();
        test_startup();
        test_default_line();
        test_small_frames();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
